mic1_step_controller: RTL and testbench

Sequences single-step and auto-repeat clock enables for the MIC-1 core from one debounced push-button. It sits between the button debouncer and the core clock-enable input. A press issues one step pulse immediately. Holding the button past a hold threshold starts auto-repeat stepping at a fixed interval. A core halt request suppresses all pulses without disturbing button tracking.

---
 rtl/mic1_step_controller.sv | 65 ++++++
 tb/tb_mic1_step_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mic1_step_controller.sv
// mic1_step_controller: single-step and auto-repeat clock-enable sequencer for the MIC-1 core
module mic1_step_controller #(
   parameter int HOLD_CYCLES   = 5_000_000,
   parameter int REPEAT_CYCLES = 500_000,
   parameter int CNT_W         = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_level,
   input  logic        cpu_halt,
   output logic        step_pulse,
   output logic        repeat_active,
   output logic [15:0] step_count
);
   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             fire, issue;
   assign issue = fire & ~cpu_halt;
   // next state and interval count; release wins over a terminal count
   always_comb begin
      state_nx = state;
      cnt_nx   = '0;
      fire     = 1'b0;
      case (state)
         IDLE: begin
            if (btn_level) begin
               state_nx = HOLD;
               fire     = 1'b1;
            end
         end
         HOLD: begin
            if (!btn_level) state_nx = IDLE;
            else if (cnt == HOLD_LAST) begin
               state_nx = REPEAT;
               fire     = 1'b1;
            end else cnt_nx = cnt + 1'b1;
         end
         REPEAT: begin
            if (!btn_level) state_nx = IDLE;
            else if (cnt == REP_LAST) fire = 1'b1;
            else cnt_nx = cnt + 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end
   // state register and registered outputs; halt only masks the strobe, not the sequencing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         step_pulse    <= 1'b0;
         repeat_active <= 1'b0;
         step_count    <= '0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         step_pulse    <= issue;
         repeat_active <= (state_nx == REPEAT);
         step_count    <= step_count + 16'(issue);
      end
   end
endmodule

// File: tb/tb_mic1_step_controller.sv
// tb_mic1_step_controller: scoreboard bench for the step controller with short hold/repeat intervals
module tb_mic1_step_controller;
   localparam int HOLD = 8;
   localparam int REP  = 4;
   typedef struct {logic p; logic r; logic [15:0] c;} exp_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        btn_level = 1'b0;
   logic        cpu_halt = 1'b0;
   logic        step_pulse, repeat_active;
   logic [15:0] step_count;
   int          errors = 0;
   int          checks = 0;
   int          held = 0;
   logic [15:0] m_cnt = '0;
   exp_t        sb[$];

   mic1_step_controller #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(24)) dut (
      .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .cpu_halt(cpu_halt),
      .step_pulse(step_pulse), .repeat_active(repeat_active), .step_count(step_count)
   );

   always #5 clk = ~clk;

   // drives one edge and pushes the expected outputs, modelled from how long the button has been held
   task automatic drive(input logic b, input logic h);
      logic f;
      btn_level = b;
      cpu_halt  = h;
      @(posedge clk);
      held = b ? held + 1 : 0;
      f = b && (held == 1 || (held > HOLD && (held - 1 - HOLD) % REP == 0));
      if (f && !h) m_cnt++;
      sb.push_back('{f && !h, held > HOLD, m_cnt});
   endtask

   task automatic model_reset();
      held  = 0;
      m_cnt = '0;
      sb.delete();
   endtask

   task automatic test_reset;
      exp_t e;
      rst_n = 1'b0;
      btn_level = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({step_pulse, repeat_active, step_count} !== 18'd0) begin
         errors++;
         $display("FAIL reset_hold: got p=%b r=%b c=%h exp all zero", step_pulse, repeat_active, step_count);
      end
      model_reset();
      rst_n = 1'b1;
      drive(1'b1, 1'b0);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({step_pulse, repeat_active, step_count} !== {e.p, e.r, e.c} || step_count !== 16'd1) begin
         errors++;
         $display("FAIL reset_first_edge: got p=%b r=%b c=%h exp p=%b r=%b c=%h", step_pulse, repeat_active, step_count, e.p, e.r, e.c);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({step_pulse, repeat_active, step_count} !== 18'd0) begin
         errors++;
         $display("FAIL reset_during_pulse: got p=%b r=%b c=%h exp all zero", step_pulse, repeat_active, step_count);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 2; t++) begin
         drive(1'b0, 1'b0);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({step_pulse, repeat_active, step_count} !== {e.p, e.r, e.c}) begin
            errors++;
            $display("FAIL reset_idle t%0d: got p=%b r=%b c=%h exp p=%b r=%b c=%h", t, step_pulse, repeat_active, step_count, e.p, e.r, e.c);
         end
      end
   endtask

   task automatic test_short_press;
      exp_t e;
      int pulses = 0;
      for (int t = 0; t < 5; t++) begin
         drive(t < 3, 1'b0);
         @(negedge clk);
         e = sb.pop_front();
         pulses += int'(step_pulse);
         checks++;
         if ({step_pulse, repeat_active, step_count} !== {e.p, e.r, e.c}) begin
            errors++;
            $display("FAIL short t%0d: got p=%b r=%b c=%h exp p=%b r=%b c=%h", t, step_pulse, repeat_active, step_count, e.p, e.r, e.c);
         end
      end
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("FAIL short_pulses: got %0d exp 1", pulses);
      end
   endtask

   task automatic test_long_press;
      exp_t e;
      int pulses = 0;
      for (int t = 0; t <= 20; t++) begin
         drive(t < 20, 1'b0);
         @(negedge clk);
         e = sb.pop_front();
         pulses += int'(step_pulse);
         checks++;
         if ({step_pulse, repeat_active, step_count} !== {e.p, e.r, e.c}) begin
            errors++;
            $display("FAIL long t%0d: got p=%b r=%b c=%h exp p=%b r=%b c=%h", t, step_pulse, repeat_active, step_count, e.p, e.r, e.c);
         end
      end
      checks++;
      if (pulses !== 4) begin
         errors++;
         $display("FAIL long_pulses: got %0d exp 4", pulses);
      end
   endtask

   task automatic test_halt;
      exp_t e;
      int pulses = 0;
      for (int t = 0; t <= 20; t++) begin
         drive(t < 20, t <= 9);
         @(negedge clk);
         e = sb.pop_front();
         pulses += int'(step_pulse);
         checks++;
         if ({step_pulse, repeat_active, step_count} !== {e.p, e.r, e.c}) begin
            errors++;
            $display("FAIL halt t%0d: got p=%b r=%b c=%h exp p=%b r=%b c=%h", t, step_pulse, repeat_active, step_count, e.p, e.r, e.c);
         end
         if (t == 8) begin
            checks++;
            if (repeat_active !== 1'b1) begin
               errors++;
               $display("FAIL halt_repeat_entry: got %b exp 1", repeat_active);
            end
         end
      end
      checks++;
      if (pulses !== 2) begin
         errors++;
         $display("FAIL halt_pulses: got %0d exp 2", pulses);
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int pulses = 0;
      for (int t = 0; t < 6; t++) begin
         drive(t % 2 == 0, 1'b0);
         @(negedge clk);
         e = sb.pop_front();
         pulses += int'(step_pulse);
         checks++;
         if ({step_pulse, repeat_active, step_count} !== {e.p, e.r, e.c}) begin
            errors++;
            $display("FAIL b2b t%0d: got p=%b r=%b c=%h exp p=%b r=%b c=%h", t, step_pulse, repeat_active, step_count, e.p, e.r, e.c);
         end
      end
      checks++;
      if (pulses !== 3) begin
         errors++;
         $display("FAIL b2b_pulses: got %0d exp 3", pulses);
      end
   endtask

   task automatic test_wrap;
      exp_t e;
      force dut.step_count = 16'hFFFF;
      #1;
      release dut.step_count;
      m_cnt = 16'hFFFF;
      for (int t = 0; t < 2; t++) begin
         drive(t == 0, 1'b0);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({step_pulse, repeat_active, step_count} !== {e.p, e.r, e.c}) begin
            errors++;
            $display("FAIL wrap t%0d: got p=%b r=%b c=%h exp p=%b r=%b c=%h", t, step_pulse, repeat_active, step_count, e.p, e.r, e.c);
         end
      end
      checks++;
      if (step_count !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_zero: got %h exp 0000", step_count);
      end
   endtask

   task automatic test_reset_mid_repeat;
      exp_t e;
      for (int t = 0; t <= 13; t++) begin
         drive(1'b1, 1'b0);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({step_pulse, repeat_active, step_count} !== {e.p, e.r, e.c}) begin
            errors++;
            $display("FAIL midrst t%0d: got p=%b r=%b c=%h exp p=%b r=%b c=%h", t, step_pulse, repeat_active, step_count, e.p, e.r, e.c);
         end
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({step_pulse, repeat_active, step_count} !== 18'd0) begin
         errors++;
         $display("FAIL midrst_clear: got p=%b r=%b c=%h exp all zero", step_pulse, repeat_active, step_count);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 3; t++) begin
         drive(t < 2, 1'b0);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({step_pulse, repeat_active, step_count} !== {e.p, e.r, e.c}) begin
            errors++;
            $display("FAIL midrst_after t%0d: got p=%b r=%b c=%h exp p=%b r=%b c=%h", t, step_pulse, repeat_active, step_count, e.p, e.r, e.c);
         end
      end
      checks++;
      if (step_count !== 16'd1) begin
         errors++;
         $display("FAIL midrst_count: got %h exp 0001", step_count);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_short_press;
      test_long_press;
      test_halt;
      test_back_to_back;
      test_wrap;
      test_reset_mid_repeat;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
